// File: rtl/exu_iter_stage.sv
// Execute stage: one-cycle ALU and branch compare, iterative shift-add MUL and restoring DIV/REM.
// Define EXU_FAST_MUL_EN to run MUL/MULH/MULHSU/MULHU through a combinational multiplier in one cycle.
module exu_iter_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            br_taken,
    output logic            busy
);
    localparam int SH_W = $clog2(XLEN);

    localparam logic [4:0] OP_ADD    = 5'd0;
    localparam logic [4:0] OP_SUB    = 5'd1;
    localparam logic [4:0] OP_AND    = 5'd2;
    localparam logic [4:0] OP_OR     = 5'd3;
    localparam logic [4:0] OP_XOR    = 5'd4;
    localparam logic [4:0] OP_SLL    = 5'd5;
    localparam logic [4:0] OP_SRL    = 5'd6;
    localparam logic [4:0] OP_SRA    = 5'd7;
    localparam logic [4:0] OP_SLT    = 5'd8;
    localparam logic [4:0] OP_SLTU   = 5'd9;
    localparam logic [4:0] OP_BEQ    = 5'd10;
    localparam logic [4:0] OP_BNE    = 5'd11;
    localparam logic [4:0] OP_BLT    = 5'd12;
    localparam logic [4:0] OP_BGE    = 5'd13;
    localparam logic [4:0] OP_BLTU   = 5'd14;
    localparam logic [4:0] OP_BGEU   = 5'd15;
    localparam logic [4:0] OP_MUL    = 5'd16;
    localparam logic [4:0] OP_MULH   = 5'd17;
    localparam logic [4:0] OP_MULHSU = 5'd18;
    localparam logic [4:0] OP_DIV    = 5'd20;
    localparam logic [4:0] OP_DIVU   = 5'd21;
    localparam logic [4:0] OP_REM    = 5'd22;

    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;

    function automatic logic [XLEN-1:0] alu_eval(input logic [4:0] f,
                                                 input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
        logic signed [XLEN-1:0] sa;
        logic signed [XLEN-1:0] sb;
        logic [SH_W-1:0]        sh;
        logic [XLEN-1:0]        r;
        sa = a;
        sb = b;
        sh = b[SH_W-1:0];
        case (f)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_SLL:  r = a << sh;
            OP_SRL:  r = a >> sh;
            OP_SRA:  r = sa >>> sh;
            OP_SLT:  r = {{(XLEN-1){1'b0}}, sa < sb};
            OP_SLTU: r = {{(XLEN-1){1'b0}}, a < b};
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic br_eval(input logic [4:0] f,
                                     input logic [XLEN-1:0] a,
                                     input logic [XLEN-1:0] b);
        logic signed [XLEN-1:0] sa;
        logic signed [XLEN-1:0] sb;
        logic                   t;
        sa = a;
        sb = b;
        case (f)
            OP_BEQ:  t = (a == b);
            OP_BNE:  t = (a != b);
            OP_BLT:  t = (sa < sb);
            OP_BGE:  t = (sa >= sb);
            OP_BLTU: t = (a < b);
            OP_BGEU: t = (a >= b);
            default: t = 1'b0;
        endcase
        return t;
    endfunction

    // Two's-complement negate when n is set; used for magnitudes and for the final sign fix-up.
    function automatic logic [XLEN-1:0] fix_sign(input logic n, input logic [XLEN-1:0] v);
        return n ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [2*XLEN-1:0] fix_sign2(input logic n, input logic [2*XLEN-1:0] v);
        return n ? (~v + 1'b1) : v;
    endfunction

    state_t            state_q, state_d;
    logic              out_valid_q, out_valid_d;
    logic              busy_q, busy_d;
    logic              br_taken_q, br_taken_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [4:0]        op_q, op_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [2*XLEN-1:0] opa_q, opa_d;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic              neg_q, neg_d;

    logic              accept;
    logic              is_mul_in, is_div_in, is_quo_in;
    logic              a_neg, b_neg;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic              div_zero, div_ovf;
    logic [2*XLEN-1:0] mul_sum, prod_fix;
    logic [XLEN:0]     rem_sh, rem_diff;
    logic [XLEN-1:0]   rem_new, quo_new, div_val;
`ifdef EXU_FAST_MUL_EN
    logic [2*XLEN-1:0] prod_in;
`endif

    assign in_ready  = ~flush & ((state_q == S_IDLE) | ((state_q == S_DONE) & out_ready));
    assign accept    = in_valid & in_ready;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign br_taken  = br_taken_q;
    assign busy      = busy_q;

    always_comb begin
        state_d    = state_q;
        result_d   = result_q;
        br_taken_d = br_taken_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        acc_d      = acc_q;
        opa_d      = opa_q;
        opb_d      = opb_q;
        neg_d      = neg_q;

        is_mul_in = (op[4:2] == 3'b100);
        is_div_in = (op[4:2] == 3'b101);
        is_quo_in = (op == OP_DIV) || (op == OP_DIVU);
        if (is_mul_in) begin
            a_neg = ((op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU)) && src1[XLEN-1];
            b_neg = ((op == OP_MUL) || (op == OP_MULH)) && src2[XLEN-1];
        end else begin
            a_neg = ((op == OP_DIV) || (op == OP_REM)) && src1[XLEN-1];
            b_neg = ((op == OP_DIV) || (op == OP_REM)) && src2[XLEN-1];
        end
        mag_a    = fix_sign(a_neg, src1);
        mag_b    = fix_sign(b_neg, src2);
        div_zero = (src2 == '0);
        div_ovf  = ((op == OP_DIV) || (op == OP_REM)) && (src1 == MOST_NEG) && (src2 == '1);
`ifdef EXU_FAST_MUL_EN
        prod_in  = fix_sign2(a_neg ^ b_neg, {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b});
`endif

        // One iteration step of each engine: shift-add multiply, restoring divide.
        mul_sum  = acc_q + (opb_q[0] ? opa_q : '0);
        prod_fix = fix_sign2(neg_q, mul_sum);
        rem_sh   = {acc_q[XLEN-1:0], opb_q[XLEN-1]};
        rem_diff = rem_sh - {1'b0, opa_q[XLEN-1:0]};
        rem_new  = rem_diff[XLEN] ? rem_sh[XLEN-1:0] : rem_diff[XLEN-1:0];
        quo_new  = {opb_q[XLEN-2:0], ~rem_diff[XLEN]};
        div_val  = ((op_q == OP_DIV) || (op_q == OP_DIVU)) ? quo_new : rem_new;

        if (flush) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else if (accept) begin
            op_d       = op;
            cnt_d      = '0;
            br_taken_d = br_eval(op, src1, src2);
            if (is_mul_in) begin
`ifdef EXU_FAST_MUL_EN
                state_d  = S_DONE;
                result_d = (op == OP_MUL) ? prod_in[XLEN-1:0] : prod_in[2*XLEN-1:XLEN];
`else
                state_d = S_ITER;
                acc_d   = '0;
                opa_d   = {{XLEN{1'b0}}, mag_a};
                opb_d   = mag_b;
                neg_d   = a_neg ^ b_neg;
`endif
            end else if (is_div_in) begin
                if (div_zero) begin
                    state_d  = S_DONE;
                    result_d = is_quo_in ? '1 : src1;
                end else if (div_ovf) begin
                    state_d  = S_DONE;
                    result_d = (op == OP_DIV) ? MOST_NEG : '0;
                end else begin
                    state_d = S_ITER;
                    acc_d   = '0;
                    opa_d   = {{XLEN{1'b0}}, mag_b};
                    opb_d   = mag_a;
                    neg_d   = is_quo_in ? (a_neg ^ b_neg) : a_neg;
                end
            end else begin
                state_d  = S_DONE;
                result_d = alu_eval(op, src1, src2);
            end
        end else if (state_q == S_ITER) begin
            cnt_d = cnt_q + 1'b1;
            if (op_q[2]) begin
                acc_d = {{XLEN{1'b0}}, rem_new};
                opb_d = quo_new;
            end else begin
                acc_d = mul_sum;
                opa_d = opa_q << 1;
                opb_d = opb_q >> 1;
            end
            if (cnt_q == CNT_W'(XLEN - 1)) begin
                state_d = S_DONE;
                cnt_d   = '0;
                if (op_q[2]) begin
                    result_d = fix_sign(neg_q, div_val);
                end else begin
                    result_d = (op_q == OP_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
                end
            end
        end else if ((state_q == S_DONE) && out_ready) begin
            state_d = S_IDLE;
        end

        out_valid_d = (state_d == S_DONE);
        busy_d      = (state_d == S_ITER);
    end

    always_ff @(posedge clk) begin
        op_q  <= op_d;
        acc_q <= acc_d;
        opa_q <= opa_d;
        opb_q <= opb_d;
        neg_q <= neg_d;
        if (rst) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            br_taken_q  <= 1'b0;
            result_q    <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            br_taken_q  <= br_taken_d;
            result_q    <= result_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule

// File: tb/tb_exu_iter_stage.sv
// Bench for exu_iter_stage: expected results are queued at accept and compared at the output
// handshake, including the cycle distance from accept to the first out_valid.
module tb_exu_iter_stage;
    localparam int XLEN = 32;
`ifdef EXU_FAST_MUL_EN
    localparam int MUL_LAT  = 1;
    localparam int MUL_BUSY = 0;
`else
    localparam int MUL_LAT  = XLEN + 1;
    localparam int MUL_BUSY = XLEN;
`endif
    localparam int DIV_LAT = XLEN + 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [4:0]      op;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            br_taken;
    logic            busy;

    typedef struct {
        logic [31:0] res;
        logic        br;
        int          lat;
        int          acc_cyc;
        logic [4:0]  op;
    } exp_t;

    exp_t exp_q[$];
    int   checks  = 0;
    int   errors  = 0;
    int   cyc     = 0;
    bit   seen    = 1'b0;
    bit   rand_bp = 1'b0;

    exu_iter_stage #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .src1      (src1),
        .src2      (src2),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .br_taken  (br_taken),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic void model(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic br, output int lat);
        logic signed [63:0] sa, sbs, ubs;
        logic signed [31:0] a32, b32;
        logic [63:0]        p;
        sa  = {{32{a[31]}}, a};
        sbs = {{32{b[31]}}, b};
        ubs = {32'b0, b};
        a32 = a;
        b32 = b;
        r   = '0;
        br  = 1'b0;
        lat = 1;
        case (o)
            5'd0:  r = a + b;
            5'd1:  r = a - b;
            5'd2:  r = a & b;
            5'd3:  r = a | b;
            5'd4:  r = a ^ b;
            5'd5:  r = a << b[4:0];
            5'd6:  r = a >> b[4:0];
            5'd7:  r = a32 >>> b[4:0];
            5'd8:  r = (a32 < b32) ? 32'd1 : 32'd0;
            5'd9:  r = (a < b) ? 32'd1 : 32'd0;
            5'd10: br = (a == b);
            5'd11: br = (a != b);
            5'd12: br = (a32 < b32);
            5'd13: br = (a32 >= b32);
            5'd14: br = (a < b);
            5'd15: br = (a >= b);
            5'd16: begin p = sa * sbs; r = p[31:0];  lat = MUL_LAT; end
            5'd17: begin p = sa * sbs; r = p[63:32]; lat = MUL_LAT; end
            5'd18: begin p = sa * ubs; r = p[63:32]; lat = MUL_LAT; end
            5'd19: begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; lat = MUL_LAT; end
            5'd20: begin
                if (b == 0) r = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
                else begin r = a32 / b32; lat = DIV_LAT; end
            end
            5'd21: begin
                if (b == 0) r = 32'hFFFF_FFFF;
                else begin r = a / b; lat = DIV_LAT; end
            end
            5'd22: begin
                if (b == 0) r = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
                else begin r = a32 % b32; lat = DIV_LAT; end
            end
            5'd23: begin
                if (b == 0) r = a;
                else begin r = a % b; lat = DIV_LAT; end
            end
            default: ;
        endcase
    endfunction

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; returns just after the accept edge.
    task automatic issue(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b, input bit push);
        exp_t e;
        int   k = 0;
        in_valid = 1'b1;
        op       = o;
        src1     = a;
        src2     = b;
        @(negedge clk);
        while (!in_ready && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) begin
            check_eq("accept_timeout", 64'd0, 64'd1);
        end else if (push) begin
            model(o, a, b, e.res, e.br, e.lat);
            e.acc_cyc = cyc;
            e.op      = o;
            exp_q.push_back(e);
        end
        sync();
        in_valid = 1'b0;
        op       = 5'($urandom);
        src1     = $urandom;
        src2     = $urandom;
    endtask

    task automatic drain();
        int k = 0;
        do begin
            @(posedge clk);
            k++;
        end while (exp_q.size() != 0 && k < 4000);
        if (exp_q.size() != 0) check_eq("drain_timeout", 64'(exp_q.size()), 64'd0);
        #1;
    endtask

    task automatic wait_valid(input string tag);
        int k = 0;
        @(negedge clk);
        while (!out_valid && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!out_valid) check_eq(tag, 64'd0, 64'd1);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    // Output monitor: latency on the first valid cycle, data at the handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (!out_valid) begin
                seen = 1'b0;
            end else if (exp_q.size() == 0) begin
                check_eq("spurious_out_valid", 64'(out_valid), 64'd0);
            end else begin
                if (!seen) begin
                    check_eq($sformatf("latency op%0d", exp_q[0].op),
                             64'(cyc - exp_q[0].acc_cyc), 64'(exp_q[0].lat));
                    seen = 1'b1;
                end
                if (out_ready) begin
                    check_eq($sformatf("result op%0d", exp_q[0].op), 64'(result), 64'(exp_q[0].res));
                    check_eq($sformatf("br_taken op%0d", exp_q[0].op), 64'(br_taken), 64'(exp_q[0].br));
                    void'(exp_q.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    initial begin
        forever begin
            sync();
            if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        int n;
        int k;
        rst       = 1'b1;
        in_valid  = 1'b0;
        op        = '0;
        src1      = '0;
        src2      = '0;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_result", 64'(result), 64'd0);
        check_eq("rst_br_taken", 64'(br_taken), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_in_ready", 64'(in_ready), 64'd1);
        sync();

        issue(5'd0, 32'hFFFF_FFFF, 32'h1, 1'b1);
        @(negedge clk);
        sync();
        @(negedge clk);
        check_eq("idle_after_add", 64'(out_valid), 64'd0);
        sync();

        issue(5'd14, 32'h1, 32'h8000_0000, 1'b1);
        issue(5'd12, 32'h1, 32'h8000_0000, 1'b1);
        drain();

        issue(5'd17, 32'h8000_0000, 32'h8000_0000, 1'b1);
        n = 0;
        k = 0;
        while (k < 100) begin
            @(negedge clk);
            if (out_valid) break;
            if (busy) n++;
            k++;
        end
        check_eq("mulh_busy_cycles", 64'(n), 64'(MUL_BUSY));
        sync();
        drain();

        issue(5'd20, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        issue(5'd21, 32'd7, 32'd0, 1'b1);
        issue(5'd23, 32'd7, 32'd0, 1'b1);
        issue(5'd22, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        issue(5'd20, 32'hFFFF_FFF9, 32'd2, 1'b1);
        drain();

        out_ready = 1'b0;
        issue(5'd22, 32'hFFFF_FFF9, 32'd2, 1'b1);
        wait_valid("rem_hold_valid_timeout");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("hold_result", 64'(result), 64'hFFFF_FFFF);
            check_eq("hold_out_valid", 64'(out_valid), 64'd1);
            check_eq("hold_in_ready", 64'(in_ready), 64'd0);
        end
        sync();
        out_ready = 1'b1;
        drain();

        // Held result dropped by flush.
        out_ready = 1'b0;
        issue(5'd0, 32'd10, 32'd20, 1'b1);
        wait_valid("flush_done_valid_timeout");
        sync();
        flush = 1'b1;
        sync();
        flush = 1'b0;
        void'(exp_q.pop_front());
        @(negedge clk);
        check_eq("flush_done_out_valid", 64'(out_valid), 64'd0);
        sync();
        out_ready = 1'b1;

        // No accept while flush is high, even when idle.
        flush    = 1'b1;
        in_valid = 1'b1;
        op       = 5'd0;
        src1     = 32'd1;
        src2     = 32'd1;
        @(negedge clk);
        check_eq("flush_in_ready", 64'(in_ready), 64'd0);
        sync();
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check_eq("flush_no_accept", 64'(out_valid), 64'd0);
        sync();

        issue(5'd21, 32'd100, 32'd3, 1'b0);
        repeat (9) sync();
        flush = 1'b1;
        @(negedge clk);
        check_eq("flush_iter_busy", 64'(busy), 64'd1);
        check_eq("flush_iter_in_ready", 64'(in_ready), 64'd0);
        sync();
        flush = 1'b0;
        @(negedge clk);
        check_eq("post_flush_busy", 64'(busy), 64'd0);
        check_eq("post_flush_in_ready", 64'(in_ready), 64'd1);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) n++;
            @(negedge clk);
        end
        check_eq("post_flush_valid_cycles", 64'(n), 64'd0);
        sync();
        issue(5'd0, 32'd2, 32'd3, 1'b1);
        drain();

        rand_bp = 1'b1;
        for (int i = 0; i < 40; i++) begin
            issue(5'($urandom_range(0, 31)), pick(), pick(), 1'b1);
        end
        drain();
        rand_bp = 1'b0;
        sync();
        out_ready = 1'b1;

        // Reset mid-operation clears the held result as well.
        issue(5'd0, 32'd40, 32'd2, 1'b1);
        drain();
        issue(5'd21, 32'd1000, 32'd7, 1'b0);
        repeat (5) sync();
        rst = 1'b1;
        sync();
        rst = 1'b0;
        @(negedge clk);
        check_eq("midrst_result", 64'(result), 64'd0);
        check_eq("midrst_br_taken", 64'(br_taken), 64'd0);
        check_eq("midrst_out_valid", 64'(out_valid), 64'd0);
        check_eq("midrst_busy", 64'(busy), 64'd0);
        check_eq("midrst_in_ready", 64'(in_ready), 64'd1);
        sync();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/exu_iter_stage.md
Name: exu_iter_stage

Overview:
- Parametrised execute stage that sits between the decode unit and the load/store unit.
- Executes integer ALU ops and branch compares in one cycle, and MUL/DIV/REM ops iteratively over multiple cycles.
- Upstream and downstream interfaces are full valid/ready handshakes. The result is registered and held until downstream accepts it.
- A flush input aborts any operation in flight.

Parameters:
- XLEN, 32, operand and result width; must be >= 8 and a power of 2.
- CNT_W, $clog2(XLEN)+1, iteration counter width; derived, do not override.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  operation offered by upstream
- in_ready  out  1  stage can accept an operation this cycle
- op  in  5  operation code, see Behaviour
- src1  in  XLEN  operand 1
- src2  in  XLEN  operand 2
- flush  in  1  abort the current operation and drop any held result
- out_valid  out  1  result held and valid
- out_ready  in  1  downstream accepts the result
- result  out  XLEN  registered result
- br_taken  out  1  registered branch decision; 0 for non-branch ops
- busy  out  1  an iterative op is in progress

Behaviour:
- Clock and reset: clk is the clock; rst is a synchronous, active-high reset.
- Reset values: state=IDLE, out_valid=0, result=0, br_taken=0, busy=0, counter=0.
- States:
  - IDLE: no operation in flight.
  - ITER: an iterative op is running.
  - DONE: a result is held for downstream.
- Accept: an operation is accepted on a clock edge where in_valid & in_ready.
  - in_ready = (state==IDLE) | (state==DONE & out_ready). This allows back-to-back acceptance.
  - src1, src2 and op are captured on the accept edge. Later changes on the inputs are ignored.
- Op codes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU.
  - 10 BEQ, 11 BNE, 12 BLT, 13 BGE, 14 BLTU, 15 BGEU.
  - 16 MUL, 17 MULH, 18 MULHSU, 19 MULHU, 20 DIV, 21 DIVU, 22 REM, 23 REMU.
  - Codes 24-31: result=0, br_taken=0, single cycle.
- Single-cycle ops (0-15 and 24-31):
  - Accept edge goes to DONE. out_valid is high on the next cycle (latency 1).
  - Shift amount = src2[$clog2(XLEN)-1:0].
  - Branch ops: result=0, br_taken = compare outcome.
- MUL ops:
  - Shift-add, 1 bit per cycle. Operands are sign-extended per op to 2*XLEN and magnitude-corrected.
  - ITER runs for exactly XLEN cycles, then DONE. out_valid goes high XLEN+1 cycles after the accept edge.
  - MUL returns the low XLEN bits of the product; MULH/MULHSU/MULHU return the high XLEN bits.
- DIV/REM ops:
  - Restoring divider, 1 bit per cycle, signed handled via magnitudes plus sign fix-up. Latency XLEN+1, same as MUL.
  - Divisor==0 goes directly to DONE (latency 1): DIV/DIVU give all-ones; REM/REMU give src1.
  - Signed overflow (src1 = most-negative, src2 = -1) goes directly to DONE: DIV gives most-negative, REM gives 0.
- DONE:
  - result, br_taken and out_valid are held stable while out_ready=0.
  - On out_ready=1 and no new accept, the next state is IDLE.
  - On out_ready=1 with a simultaneous accept, the next state is DONE or ITER for the new op.
- busy = (state==ITER).
- Flush:
  - Highest priority after rst. The next state is IDLE, out_valid=0 on the next cycle, and the counter clears.
  - in_ready is forced to 0 during the flush cycle, so no accept occurs.
  - result keeps its last value and is don't-care while out_valid=0.
- Reset mid-operation: identical to flush, and additionally result=0 and br_taken=0.
- Arithmetic: all add/sub ops wrap modulo 2^XLEN. No exceptions are raised.

Optional Feature:
- Macro: EXU_FAST_MUL_EN.
- When defined: ops 16-19 use a combinational 2*XLEN multiplier and take the single-cycle path (latency 1, never enter ITER). The divider is unchanged.
- When undefined: the iterative multiplier described above is used. Results are bit-identical in both builds; only latency differs.

Test Plan:
- Reset then ADD src1=0xFFFFFFFF, src2=1 with out_ready=1 -> out_valid on cycle 1, result=0x00000000, br_taken=0, then IDLE.
- BLTU src1=1, src2=0x80000000 -> br_taken=1, result=0. BLT with the same operands -> br_taken=0.
- MULH src1=0x80000000, src2=0x80000000, XLEN=32 -> busy for 32 cycles, out_valid on cycle 33, result=0x40000000. With EXU_FAST_MUL_EN -> cycle 1, same value.
- DIV src1=0x80000000, src2=0xFFFFFFFF -> result=0x80000000, latency 1. DIVU 7/0 -> 0xFFFFFFFF. REMU 7/0 -> 7.
- DIV src1=-7 (0xFFFFFFF9), src2=2 -> result=0xFFFFFFFD after 33 cycles. REM -> 0xFFFFFFFF. Hold out_ready=0 for 5 cycles -> result stable, in_ready=0.
- Issue DIVU, assert flush on ITER cycle 10 -> IDLE next cycle, out_valid never rises. The next ADD 2+3 gives 5 with latency 1.
